multi_clk_en_gen: RTL and testbench

- Parametrised multi-channel clock-enable generator for the camera/UART datapath.
- Runs from the single board reference clock. Each channel has a phase-accumulator (NCO) divider that produces one-cycle tick strobes at refclk*inc/2^ACC_W.
- Supports a per-channel start phase, runtime reconfiguration over a valid/ready port, and a lock/settle indicator.
- Gives downstream logic one-clock-domain equivalents of several derived clocks, e.g. 24 MHz sensor strobe and UART baud tick from 50 MHz.

---
 rtl/clk_en_pkg.sv | 20 ++
 rtl/nco_channel.sv | 59 +++++
 rtl/multi_clk_en_gen.sv | 155 +++++++++++++++
 tb/tb_multi_clk_en_gen.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_en_pkg.sv
// Shared types and constants for the multi-channel clock-enable generator.
//   state_e              : controller states (SETTLE, LOCKED, APPLY)
//   DEFAULT_INC_50_TO_24 : increment giving a 24 MHz strobe from a 50 MHz refclk
//   settle_cnt_w()       : width of a counter that can hold 0..lock_cycles
package clk_en_pkg;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        LOCKED = 2'd1,
        APPLY  = 2'd2
    } state_e;

    // 24/50 * 2^32
    localparam logic [31:0] DEFAULT_INC_50_TO_24 = 32'h7AE1_47AE;

    function automatic int unsigned settle_cnt_w(input int unsigned lock_cycles);
        return $clog2(lock_cycles + 1);
    endfunction

endpackage

// File: rtl/nco_channel.sv
// One phase-accumulator divider channel.
// Ports:
//   refclk      : clock, rising edge
//   rst         : asynchronous active-high reset
//   load        : replace inc/en/acc with the load_* values this cycle (no add)
//   load_inc    : new increment
//   load_phase  : new accumulator value
//   load_en     : new run enable
//   tick_raw    : combinational carry out of acc+inc, i.e. the accumulator
//                 overflows on the coming edge (0 while loading or disabled)
module nco_channel #(
    parameter int unsigned       ACC_W   = 32,
    parameter logic [ACC_W-1:0]  RST_INC = '0
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             load,
    input  logic [ACC_W-1:0] load_inc,
    input  logic [ACC_W-1:0] load_phase,
    input  logic             load_en,
    output logic             tick_raw
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic             en_q, en_d;
    logic [ACC_W:0]   sum;

    // Next-state: load wins over accumulate; a disabled channel holds its phase.
    always_comb begin
        sum      = {1'b0, acc_q} + {1'b0, inc_q};
        acc_d    = acc_q;
        inc_d    = inc_q;
        en_d     = en_q;
        tick_raw = 1'b0;
        if (load) begin
            acc_d = load_phase;
            inc_d = load_inc;
            en_d  = load_en;
        end else if (en_q) begin
            acc_d    = sum[ACC_W-1:0];
            tick_raw = sum[ACC_W];
        end
    end

    // Channel registers.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            inc_q <= RST_INC;
            en_q  <= 1'b1;
        end else begin
            acc_q <= acc_d;
            inc_q <= inc_d;
            en_q  <= en_d;
        end
    end

endmodule

// File: rtl/multi_clk_en_gen.sv
// Multi-channel clock-enable generator: NUM_CH NCO dividers on one refclk,
// each producing single-cycle tick strobes at refclk*inc/2^ACC_W, plus a
// settle/lock controller and a valid/ready reconfiguration port.
// Ports:
//   refclk     : sole clock, rising edge
//   rst        : asynchronous active-high reset
//   cfg_valid  : configuration request
//   cfg_ready  : request accepted on this edge when high (only while locked)
//   cfg_chan   : target channel index
//   cfg_inc    : new increment
//   cfg_phase  : accumulator start value
//   cfg_enable : channel run enable
//   cfg_err    : one-cycle pulse after a request named a channel >= NUM_CH
//   tick       : per-channel one-cycle strobes, masked while not locked
//   locked     : outputs valid and stable
module multi_clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int unsigned      NUM_CH      = 4,
    parameter int unsigned      ACC_W       = 32,
    parameter int unsigned      LOCK_CYCLES = 16,
    parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(DEFAULT_INC_50_TO_24)
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_chan,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    input  logic              cfg_enable,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic              locked
);

    localparam int unsigned CNT_W  = settle_cnt_w(LOCK_CYCLES);
    localparam int unsigned CHAN_W = 4;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CHAN_W-1:0]   chan_q, chan_d;
    logic [ACC_W-1:0]    inc_q, inc_d;
    logic [ACC_W-1:0]    phase_q, phase_d;
    logic                en_q, en_d;
    logic                locked_q, locked_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [NUM_CH-1:0]   tick_q, tick_d;

    logic                accept;
    logic                chan_ok;
    logic [NUM_CH-1:0]   load;
    logic [NUM_CH-1:0]   tick_raw;

    assign accept  = cfg_valid & ready_q;
    assign chan_ok = (32'(cfg_chan) < NUM_CH);

    // Channel bank; only the captured channel loads, and only in APPLY.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load[i] = (state_q == APPLY) && (chan_q == CHAN_W'(i));

        nco_channel #(
            .ACC_W   (ACC_W),
            .RST_INC (DEFAULT_INC)
        ) u_nco (
            .refclk     (refclk),
            .rst        (rst),
            .load       (load[i]),
            .load_inc   (inc_q),
            .load_phase (phase_q),
            .load_en    (en_q),
            .tick_raw   (tick_raw[i])
        );
    end

    // Controller next-state and registered-output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chan_d  = chan_q;
        inc_d   = inc_q;
        phase_d = phase_q;
        en_d    = en_q;
        err_d   = 1'b0;

        unique case (state_q)
            SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (accept) begin
                    if (chan_ok) begin
                        state_d = APPLY;
                        chan_d  = cfg_chan;
                        inc_d   = cfg_inc;
                        phase_d = cfg_phase;
                        en_d    = cfg_enable;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            APPLY: begin
                cnt_d   = '0;
                state_d = SETTLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = SETTLE;
            end
        endcase

        // Outputs follow the state being entered so tick and locked agree.
        locked_d = (state_d == LOCKED);
        ready_d  = locked_d;
        tick_d   = tick_raw & {NUM_CH{locked_d}};
    end

    // Controller registers.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q  <= SETTLE;
            cnt_q    <= '0;
            chan_q   <= '0;
            inc_q    <= '0;
            phase_q  <= '0;
            en_q     <= 1'b0;
            locked_q <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            tick_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            chan_q   <= chan_d;
            inc_q    <= inc_d;
            phase_q  <= phase_d;
            en_q     <= en_d;
            locked_q <= locked_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            tick_q   <= tick_d;
        end
    end

    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;
    assign tick      = tick_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_multi_clk_en_gen.sv
module tb_multi_clk_en_gen;

    localparam int unsigned      NUM_CH      = 4;
    localparam int unsigned      ACC_W       = 32;
    localparam int unsigned      LOCK_CYCLES = 16;
    localparam logic [ACC_W-1:0] DEF_INC     = 32'h7AE1_47AE;
    localparam longint unsigned  MOD         = 64'd1 << ACC_W;

    logic              refclk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [3:0]        cfg_chan = '0;
    logic [ACC_W-1:0]  cfg_inc = '0;
    logic [ACC_W-1:0]  cfg_phase = '0;
    logic              cfg_enable = 1'b0;
    logic              cfg_err;
    logic [NUM_CH-1:0] tick;
    logic              locked;

    int n_assert = 0;
    int n_fail   = 0;

    multi_clk_en_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_CYCLES),
        .DEFAULT_INC (DEF_INC)
    ) u_dut (
        .refclk     (refclk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_inc    (cfg_inc),
        .cfg_phase  (cfg_phase),
        .cfg_enable (cfg_enable),
        .cfg_err    (cfg_err),
        .tick       (tick),
        .locked     (locked)
    );

    always #5 refclk = ~refclk;

    // ---------------- reference model (edge-count based) ----------------
    longint unsigned   m_acc [NUM_CH];
    longint unsigned   m_inc [NUM_CH];
    bit                m_en  [NUM_CH];
    int                m_edge      = 0;
    int                m_lock_edge = LOCK_CYCLES;   // -1: no lock scheduled
    bit                m_pend      = 1'b0;
    int                m_chan      = 0;
    longint unsigned   m_cinc      = 0;
    longint unsigned   m_cph       = 0;
    bit                m_cen       = 1'b0;
    logic              exp_locked  = 1'b0;
    logic              exp_err     = 1'b0;
    logic [NUM_CH-1:0] exp_tick    = '0;

    always @(posedge refclk or posedge rst) begin
        logic [NUM_CH-1:0] carry;
        bit                acc_ok;
        longint unsigned   s;
        if (rst) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                m_acc[i] = 0;
                m_inc[i] = longint'(DEF_INC);
                m_en[i]  = 1'b1;
            end
            m_edge      = 0;
            m_lock_edge = LOCK_CYCLES;
            m_pend      = 1'b0;
            exp_locked  = 1'b0;
            exp_err     = 1'b0;
            exp_tick    = '0;
        end else begin
            acc_ok = cfg_valid && exp_locked;
            m_edge++;
            carry = '0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (m_pend && i == m_chan) begin
                    m_acc[i] = m_cph;
                    m_inc[i] = m_cinc;
                    m_en[i]  = m_cen;
                end else if (m_en[i]) begin
                    s        = m_acc[i] + m_inc[i];
                    carry[i] = (s >= MOD);
                    m_acc[i] = s % MOD;
                end
            end
            if (m_pend) begin
                m_pend      = 1'b0;
                m_lock_edge = m_edge + int'(LOCK_CYCLES);
            end
            exp_err = acc_ok && (int'(cfg_chan) >= int'(NUM_CH));
            if (acc_ok && int'(cfg_chan) < int'(NUM_CH)) begin
                m_pend      = 1'b1;
                m_chan      = int'(cfg_chan);
                m_cinc      = longint'(cfg_inc);
                m_cph       = longint'(cfg_phase);
                m_cen       = cfg_enable;
                m_lock_edge = -1;
            end
            exp_locked = (m_lock_edge >= 0) && (m_edge >= m_lock_edge);
            exp_tick   = carry & {NUM_CH{exp_locked}};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_lock();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge refclk);
            if (locked === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL lock_timeout: locked=%b after 200 cycles, required 1", locked);
        end
    endtask

    // Present a request and return just after the edge that accepts it.
    task automatic send_cfg(input logic [3:0] ch, input logic [ACC_W-1:0] inc,
                            input logic [ACC_W-1:0] ph, input logic en);
        bit ok;
        ok         = 1'b0;
        cfg_valid  = 1'b1;
        cfg_chan   = ch;
        cfg_inc    = inc;
        cfg_phase  = ph;
        cfg_enable = en;
        for (int k = 0; k < 200; k++) begin
            if (cfg_ready === 1'b1) begin
                @(posedge refclk);
                #1;
                ok = 1'b1;
                break;
            end
            @(negedge refclk);
        end
        // Scramble fields after accept; they must have no effect.
        cfg_valid  = 1'b0;
        cfg_chan   = 4'($urandom);
        cfg_inc    = $urandom;
        cfg_phase  = $urandom;
        cfg_enable = 1'($urandom);
        n_assert++;
        if (!ok) begin
            n_fail++;
            $display("FAIL cfg_accept_timeout: cfg_ready=%b, required 1 within 200 cycles", cfg_ready);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic want;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        repeat (3) @(negedge refclk);
        n_assert++;
        if (tick !== '0 || locked !== 1'b0 || cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: tick=%b locked=%b ready=%b err=%b, required all 0",
                     tick, locked, cfg_ready, cfg_err);
        end
        rst = 1'b0;
        for (int k = 1; k <= int'(LOCK_CYCLES) + 2; k++) begin
            @(negedge refclk);
            want = (k >= int'(LOCK_CYCLES));
            n_assert++;
            if (locked !== want || cfg_ready !== want) begin
                n_fail++;
                $display("FAIL reset_lock_edge%0d: locked=%b ready=%b, required %b", k, locked, cfg_ready, want);
            end
            n_assert++;
            if (tick !== exp_tick || (!want && tick !== '0)) begin
                n_fail++;
                $display("FAIL reset_tick_edge%0d: tick=%b, required %b", k, tick, exp_tick);
            end
        end
    endtask

    task automatic test_defaults();
        int                cnt [NUM_CH];
        bit                consec [NUM_CH];
        logic [NUM_CH-1:0] prev;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            cnt[c]    = 0;
            consec[c] = 1'b0;
        end
        wait_lock();
        prev = '0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge refclk);
            n_assert++;
            if (tick !== exp_tick || locked !== 1'b1) begin
                n_fail++;
                $display("FAIL defaults_cycle%0d: tick=%b locked=%b, required tick=%b locked=1", n, tick, locked, exp_tick);
            end
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (tick[c] === 1'b1) cnt[c]++;
                if (tick[c] === 1'b1 && prev[c] === 1'b1) consec[c] = 1'b1;
            end
            prev = tick;
        end
        for (int c = 0; c < int'(NUM_CH); c++) begin
            n_assert++;
            if (cnt[c] < 479 || cnt[c] > 481) begin
                n_fail++;
                $display("FAIL defaults_rate_ch%0d: %0d ticks in 1000 cycles, required 480+-1", c, cnt[c]);
            end
            n_assert++;
            if (consec[c]) begin
                n_fail++;
                $display("FAIL defaults_consecutive_ch%0d: back-to-back ticks seen, required none", c);
            end
        end
    endtask

    task automatic test_alternate();
        logic prev0;
        send_cfg(4'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_lock();
        send_cfg(4'd0, 32'h8000_0000, 32'h0000_0000, 1'b1);
        wait_lock();
        prev0 = tick[0];
        for (int n = 0; n < 20; n++) begin
            @(negedge refclk);
            n_assert++;
            if (tick !== exp_tick || tick[0] === tick[1] || tick[0] === prev0) begin
                n_fail++;
                $display("FAIL alternate_cycle%0d: tick=%b prev0=%b, required %b with ch0/ch1 alternating",
                         n, tick, prev0, exp_tick);
            end
            prev0 = tick[0];
        end
    endtask

    task automatic test_bad_chan();
        send_cfg(4'd5, 32'h1234_5678, 32'h0, 1'b1);
        @(negedge refclk);
        n_assert++;
        if (cfg_err !== 1'b1 || exp_err !== 1'b1 || locked !== 1'b1 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_chan_err: err=%b locked=%b ready=%b, required err=1 locked=1 ready=1",
                     cfg_err, locked, cfg_ready);
        end
        n_assert++;
        if (tick !== exp_tick) begin
            n_fail++;
            $display("FAIL bad_chan_tick: tick=%b, required %b", tick, exp_tick);
        end
        @(negedge refclk);
        n_assert++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_chan_pulse_len: err=%b, required 0 on second cycle", cfg_err);
        end
        for (int n = 0; n < 10; n++) begin
            @(negedge refclk);
            n_assert++;
            if (tick !== exp_tick || tick[0] === tick[1] || locked !== 1'b1) begin
                n_fail++;
                $display("FAIL bad_chan_pattern%0d: tick=%b locked=%b, required %b locked=1", n, tick, locked, exp_tick);
            end
        end
    endtask

    task automatic test_inc_zero_disable();
        send_cfg(4'd2, '0, $urandom, 1'b1);
        wait_lock();
        for (int n = 0; n < 100; n++) begin
            @(negedge refclk);
            n_assert++;
            if (tick !== exp_tick || tick[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL inc_zero_cycle%0d: tick=%b, required %b with ch2=0", n, tick, exp_tick);
            end
        end
        send_cfg(4'd3, DEF_INC, $urandom, 1'b0);
        wait_lock();
        for (int n = 0; n < 100; n++) begin
            @(negedge refclk);
            n_assert++;
            if (tick !== exp_tick || tick[3] !== 1'b0 || tick[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL disable_cycle%0d: tick=%b, required %b with ch2=ch3=0", n, tick, exp_tick);
            end
        end
    endtask

    task automatic test_rst_mid();
        int   cnt [NUM_CH];
        logic want;
        for (int c = 0; c < int'(NUM_CH); c++) cnt[c] = 0;
        // Reset while the accepted request is in APPLY.
        send_cfg(4'd0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
        #1 rst = 1'b1;
        #1;
        n_assert++;
        if (tick !== '0 || locked !== 1'b0 || cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_apply_outputs: tick=%b locked=%b ready=%b err=%b, required all 0",
                     tick, locked, cfg_ready, cfg_err);
        end
        @(negedge refclk);
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge refclk);
            n_assert++;
            if (locked !== 1'b0 || tick !== '0) begin
                n_fail++;
                $display("FAIL rst_apply_settle%0d: locked=%b tick=%b, required 0/0", k, locked, tick);
            end
        end
        // Reset again mid-settle.
        rst = 1'b1;
        #1;
        n_assert++;
        if (tick !== '0 || locked !== 1'b0 || cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_settle_outputs: tick=%b locked=%b ready=%b err=%b, required all 0",
                     tick, locked, cfg_ready, cfg_err);
        end
        @(negedge refclk);
        rst = 1'b0;
        for (int k = 1; k <= int'(LOCK_CYCLES) + 1; k++) begin
            @(negedge refclk);
            want = (k >= int'(LOCK_CYCLES));
            n_assert++;
            if (locked !== want || tick !== exp_tick) begin
                n_fail++;
                $display("FAIL rst_relock_edge%0d: locked=%b tick=%b, required locked=%b tick=%b",
                         k, locked, tick, want, exp_tick);
            end
        end
        // All channels back on the default increment.
        for (int n = 0; n < 100; n++) begin
            @(negedge refclk);
            for (int c = 0; c < int'(NUM_CH); c++) if (tick[c] === 1'b1) cnt[c]++;
        end
        for (int c = 0; c < int'(NUM_CH); c++) begin
            n_assert++;
            if (cnt[c] < 47 || cnt[c] > 49) begin
                n_fail++;
                $display("FAIL rst_default_rate_ch%0d: %0d ticks in 100 cycles, required 48+-1", c, cnt[c]);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            @(negedge refclk);
            n_assert++;
            if (tick !== exp_tick || locked !== exp_locked || cfg_ready !== exp_locked || cfg_err !== exp_err) begin
                n_fail++;
                $display("FAIL random_cycle%0d: tick=%b locked=%b ready=%b err=%b, required tick=%b locked=%b ready=%b err=%b",
                         n, tick, locked, cfg_ready, cfg_err, exp_tick, exp_locked, exp_locked, exp_err);
            end
            cfg_valid  = ($urandom_range(0, 7) == 0);
            cfg_chan   = 4'($urandom_range(0, 5));
            case ($urandom_range(0, 3))
                0:       cfg_inc = '0;
                1:       cfg_inc = 32'h8000_0000;
                2:       cfg_inc = 32'($urandom_range(0, 255)) << 24;
                default: cfg_inc = $urandom;
            endcase
            cfg_phase  = $urandom;
            cfg_enable = ($urandom_range(0, 3) != 0);
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_alternate();
        test_bad_chan();
        test_inc_zero_disable();
        test_rst_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
